time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_CNT, default 1_000_000_000: number of idle iClk cycles in a set state before the edit is abandoned (10 s at 100 MHz).
REQ-002 Parameter BLINK_CNT, default 50_000_000: iClk cycles per oBlink half-period (0.5 s at 100 MHz).
REQ-003 Counter widths SHALL be $clog2 of the corresponding parameter.
REQ-004 iClk  input  1  system clock, rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-high.
REQ-006 iBtnMode  input  1  single-cycle debounced tick: enter set mode, advance field, commit.
REQ-007 iBtnUp  input  1  single-cycle debounced tick: increment selected field.
REQ-008 iBtnDown  input  1  single-cycle debounced tick: decrement selected field.
REQ-009 iHour  input  5  live hour (0-23) from the clock counter.
REQ-010 iMin  input  6  live minute (0-59).
REQ-011 iSec  input  6  live second (0-59).
REQ-012 oHour  output  5  edit (shadow) hour.
REQ-013 oMin  output  6  edit (shadow) minute.
REQ-014 oSec  output  6  edit (shadow) second.
REQ-015 oLoad  output  1  one-cycle pulse: clock counter loads oHour/oMin/oSec.
REQ-016 oSetMode  output  1  high in any set state; display shows shadow values.
REQ-017 oField  output  2  0 none, 1 hour, 2 minute, 3 second.
REQ-018 oBlink  output  1  blink enable for the selected display field.

Function
REQ-019 FSM states SHALL be RUN, SET_HOUR, SET_MIN, SET_SEC; all outputs registered.
REQ-020 RUN + iBtnMode: capture iHour/iMin/iSec into shadow registers, go to SET_HOUR at the same edge.
REQ-021 SET_HOUR + iBtnMode -> SET_MIN; SET_MIN + iBtnMode -> SET_SEC.
REQ-022 SET_SEC + iBtnMode -> RUN, with oLoad = 1 for exactly the one cycle following that edge; shadow values unchanged during that cycle.
REQ-023 In RUN, iBtnUp/iBtnDown SHALL be ignored and shadow registers SHALL hold.
REQ-024 In a set state, iBtnUp increments the selected field: hour 23 -> 0, min/sec 59 -> 0.
REQ-025 In a set state, iBtnDown decrements the selected field: hour 0 -> 23, min/sec 0 -> 59.
REQ-026 Non-selected fields SHALL hold.
REQ-027 iBtnUp and iBtnDown in the same cycle: no change to the field.
REQ-028 iBtnMode with iBtnUp or iBtnDown in the same cycle: mode wins; up/down ignored.
REQ-029 The idle counter SHALL clear on entry to SET_HOUR and on any tick in a set state, and increment otherwise in set states.
REQ-030 If the idle counter reaches TIMEOUT_CNT-1 with no tick, go to RUN at the next edge with no oLoad pulse.
REQ-031 The idle counter SHALL hold at 0 in RUN.
REQ-032 oBlink SHALL be 1 on entry to SET_HOUR and toggle every BLINK_CNT cycles while in a set state.
REQ-033 The blink counter and oBlink SHALL restart (oBlink = 1) on every field change.
REQ-034 oBlink SHALL be 0 in RUN.
REQ-035 oSetMode = 1 and oField = 1/2/3 in SET_HOUR/SET_MIN/SET_SEC; oSetMode = 0 and oField = 0 in RUN.

Reset
REQ-036 iRst high SHALL immediately force state RUN and clear oHour, oMin, oSec, oLoad, oSetMode, oField, oBlink and both counters to 0.
REQ-037 iRst asserted mid-edit SHALL abandon the edit without an oLoad pulse.

Verification
REQ-038 The bench SHALL use TIMEOUT_CNT = 20 and BLINK_CNT = 4.
REQ-039 Basic edit: iHour = 12, iMin = 34, iSec = 56, then the following ticks:
- Mode
- Up x2
- Mode
- Down
- Mode
- Mode

Required response: exactly one oLoad pulse with oHour = 14, oMin = 33, oSec = 56; oField sequence 1, 2, 3, 0.
REQ-040 Wrap: in SET_HOUR at 23, Up -> 0, then Down -> 23. In SET_MIN at 0, Down -> 59.
REQ-041 Simultaneous ticks:
- Up + Down in the same cycle -> field unchanged.
- Mode + Up in the same cycle in SET_HOUR -> SET_MIN, hour unchanged.

REQ-042 Timeout: enter SET_MIN with no further ticks -> RUN 20 cycles later, oLoad never asserted. A tick at idle count 15 delays exit by a further 20 cycles.
REQ-043 Blink: in a set state, oBlink toggles every 4 cycles and restarts at 1 on a field change; oBlink = 0 in RUN.
REQ-044 Reset during SET_SEC: all outputs 0 asynchronously, no oLoad; a subsequent Mode tick re-enters SET_HOUR capturing the live time.

Source files
------------

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : time_set_ctrl
// Brief   : Three-field (h/m/s) time-set editor with blink and idle timeout.
// Revision: 1.0
// ============================================================================
module time_set_ctrl #(
  parameter int TIMEOUT_CNT = 1_000_000_000,
  parameter int BLINK_CNT   = 50_000_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iBtnMode,
  input  logic       iBtnUp,
  input  logic       iBtnDown,
  input  logic [4:0] iHour,
  input  logic [5:0] iMin,
  input  logic [5:0] iSec,
  output logic [4:0] oHour,
  output logic [5:0] oMin,
  output logic [5:0] oSec,
  output logic       oLoad,
  output logic       oSetMode,
  output logic [1:0] oField,
  output logic       oBlink
);

  localparam int c_IDLE_W  = $clog2(TIMEOUT_CNT);
  localparam int c_BLINK_W = $clog2(BLINK_CNT);
  localparam logic [c_IDLE_W-1:0]  c_IDLE_MAX  = c_IDLE_W'(TIMEOUT_CNT - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_CNT - 1);

  // State codes double as the oField value.
  localparam logic [1:0] c_RUN      = 2'd0;
  localparam logic [1:0] c_SET_HOUR = 2'd1;
  localparam logic [1:0] c_SET_MIN  = 2'd2;
  localparam logic [1:0] c_SET_SEC  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [4:0]           r_hour, w_hour_nxt;
  logic [5:0]           r_min, w_min_nxt;
  logic [5:0]           r_sec, w_sec_nxt;
  logic                 r_load, w_load_nxt;
  logic                 r_set_mode, w_set_mode_nxt;
  logic                 r_blink, w_blink_nxt;
  logic [c_IDLE_W-1:0]  r_idle, w_idle_nxt;
  logic [c_BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nxt;

  logic w_tick;
  logic w_up;
  logic w_down;
  logic w_timeout;

  assign w_tick    = iBtnMode | iBtnUp | iBtnDown;
  assign w_up      = iBtnUp & ~iBtnDown & ~iBtnMode;
  assign w_down    = iBtnDown & ~iBtnUp & ~iBtnMode;
  assign w_timeout = ~w_tick && (r_idle == c_IDLE_MAX);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= c_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_RUN: begin
        if (iBtnMode) w_state_nxt = c_SET_HOUR;
      end
      c_SET_HOUR: begin
        if (iBtnMode)       w_state_nxt = c_SET_MIN;
        else if (w_timeout) w_state_nxt = c_RUN;
      end
      c_SET_MIN: begin
        if (iBtnMode)       w_state_nxt = c_SET_SEC;
        else if (w_timeout) w_state_nxt = c_RUN;
      end
      default: begin
        if (iBtnMode || w_timeout) w_state_nxt = c_RUN;
      end
    endcase
  end

  always_comb begin
    w_hour_nxt      = r_hour;
    w_min_nxt       = r_min;
    w_sec_nxt       = r_sec;
    w_load_nxt      = (r_state == c_SET_SEC) && iBtnMode;
    w_set_mode_nxt  = (w_state_nxt != c_RUN);
    w_idle_nxt      = r_idle;
    w_blink_nxt     = r_blink;
    w_blink_cnt_nxt = r_blink_cnt;

    case (r_state)
      c_RUN: begin
        if (iBtnMode) begin
          w_hour_nxt = iHour;
          w_min_nxt  = iMin;
          w_sec_nxt  = iSec;
        end
      end
      c_SET_HOUR: begin
        if (w_up)   w_hour_nxt = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        if (w_down) w_hour_nxt = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
      end
      c_SET_MIN: begin
        if (w_up)   w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        if (w_down) w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
      end
      default: begin
        if (w_up)   w_sec_nxt = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
        if (w_down) w_sec_nxt = (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
      end
    endcase

    if (w_state_nxt == c_RUN || w_tick) begin
      w_idle_nxt = '0;
    end else begin
      w_idle_nxt = r_idle + c_IDLE_W'(1);
    end

    // A change of selected field restarts the blink phase lit.
    if (w_state_nxt == c_RUN) begin
      w_blink_nxt     = 1'b0;
      w_blink_cnt_nxt = '0;
    end else if (w_state_nxt != r_state) begin
      w_blink_nxt     = 1'b1;
      w_blink_cnt_nxt = '0;
    end else if (r_blink_cnt == c_BLINK_MAX) begin
      w_blink_nxt     = ~r_blink;
      w_blink_cnt_nxt = '0;
    end else begin
      w_blink_cnt_nxt = r_blink_cnt + c_BLINK_W'(1);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_load      <= 1'b0;
      r_set_mode  <= 1'b0;
      r_blink     <= 1'b0;
      r_idle      <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_hour      <= w_hour_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_load      <= w_load_nxt;
      r_set_mode  <= w_set_mode_nxt;
      r_blink     <= w_blink_nxt;
      r_idle      <= w_idle_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  assign oHour    = r_hour;
  assign oMin     = r_min;
  assign oSec     = r_sec;
  assign oLoad    = r_load;
  assign oSetMode = r_set_mode;
  assign oField   = r_state;
  assign oBlink   = r_blink;

endmodule
`default_nettype wire
